// File: rtl/ram_report_pkg.sv
// Shared constants, state enums and byte classification for the RAM-test
// error-report receive path.
package ram_report_pkg;

    localparam logic [7:0] MARK_FREQ            = 8'h7F;
    localparam logic [7:0] MARK_ERR             = 8'h40;
    localparam int         DEFAULT_CLKS_PER_BIT = 434;

    // Top bits of a data byte (0x00-0x3F), and of a legal high-address byte (0x00-0x0F)
    localparam logic [1:0] DATA_TOP = 2'b00;
    localparam logic [1:0] HI_TOP   = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        EXPECT_LO,
        EXPECT_HI
    } dec_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        BC_DATA,
        BC_ERR,
        BC_FREQ_VAL,
        BC_FREQ,
        BC_ILLEGAL
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        byte_class_t c;
        if (b[7])
            c = BC_ILLEGAL;
        else if (b == MARK_FREQ)
            c = BC_FREQ;
        else if (b == MARK_ERR)
            c = BC_ERR;
        else if (b[7:6] == DATA_TOP)
            c = BC_DATA;
        else
            c = BC_FREQ_VAL;
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, centre sampling, stop-bit frame check.
module uart_rx_byte
    import ram_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state, state_nxt;
    logic             rxd_s1, rxd_s2;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_clr, take_bit, stop_ok, stop_bad;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= RX_WAIT_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        take_bit  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            // After reset the line may be mid-byte; only a high level means idle.
            RX_WAIT_IDLE: if (rxd_s2) state_nxt = RX_IDLE;
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (!rxd_s2) state_nxt = RX_START;
            end
            RX_START: if (clk_cnt == HALF_M1) begin
                cnt_clr   = 1'b1;
                state_nxt = rxd_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (clk_cnt == FULL_M1) begin
                cnt_clr  = 1'b1;
                take_bit = 1'b1;
                if (bit_idx == 3'd7) state_nxt = RX_STOP;
            end
            RX_STOP: if (clk_cnt == FULL_M1) begin
                cnt_clr   = 1'b1;
                stop_ok   = rxd_s2;
                stop_bad  = !rxd_s2;
                state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_WAIT_IDLE;
        endcase
    end

    // Synchroniser resets low so the idle wait sees a genuine line-high level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rxd_s1    <= 1'b0;
            rxd_s2    <= 1'b0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            rxd_s1    <= UART_RXD;
            rxd_s2    <= rxd_s1;
            clk_cnt   <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (state == RX_IDLE)
                bit_idx <= '0;
            else if (take_bit)
                bit_idx <= bit_idx + 3'd1;
            if (take_bit)
                shift <= {rxd_s2, shift[7:1]};
            rx_valid  <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok)
                rx_data <= shift;
        end
    end

endmodule

// File: rtl/ram_report_rx.sv
// Error-report decoder: turns the received byte stream into failing-address
// records, frequency markers and protocol-error pulses.
module ram_report_rx
    import ram_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        UART_RXD,
    output logic        rec_valid,
    output logic [9:0]  rec_addr,
    output logic        rec_slot,
    output logic [8:0]  rec_freq_idx,
    output logic        freq_mark,
    output logic [15:0] err_count,
    output logic        proto_err,
    output logic        frame_err
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    logic       rx_vld_p0;
    logic [7:0] rx_data_p0;

    dec_state_t state, state_nxt;
    logic [5:0] lo, lo_nxt;
    logic       slot, slot_nxt;
    logic       emit, mark, perr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .UART_RXD (UART_RXD),
        .rx_valid (rx_vld_p0),
        .rx_data  (rx_data_p0),
        .frame_err(frame_err)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lo_nxt    = lo;
        slot_nxt  = slot;
        emit      = 1'b0;
        mark      = 1'b0;
        perr      = 1'b0;
        if (rx_vld_p0) begin
            case (classify(rx_data_p0))
                BC_ILLEGAL: perr = 1'b1;
                // A marker inside a pair flags the broken pair, then acts normally.
                BC_FREQ: begin
                    mark      = 1'b1;
                    perr      = (state == EXPECT_HI);
                    state_nxt = IDLE;
                end
                BC_ERR: begin
                    perr      = (state == EXPECT_HI);
                    slot_nxt  = 1'b0;
                    state_nxt = EXPECT_LO;
                end
                BC_DATA: begin
                    case (state)
                        IDLE: perr = 1'b1;
                        EXPECT_LO: begin
                            lo_nxt    = rx_data_p0[5:0];
                            state_nxt = EXPECT_HI;
                        end
                        EXPECT_HI: begin
                            if (rx_data_p0[5:4] == HI_TOP) begin
                                emit      = 1'b1;
                                slot_nxt  = 1'b1;
                                state_nxt = slot ? IDLE : EXPECT_LO;
                            end else begin
                                perr      = 1'b1;
                                state_nxt = EXPECT_LO;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Decoded byte -> registered record/marker outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lo           <= '0;
            slot         <= 1'b0;
            rec_valid    <= 1'b0;
            rec_addr     <= '0;
            rec_slot     <= 1'b0;
            rec_freq_idx <= '0;
            freq_mark    <= 1'b0;
            err_count    <= '0;
            proto_err    <= 1'b0;
        end else begin
            lo        <= lo_nxt;
            slot      <= slot_nxt;
            rec_valid <= emit;
            freq_mark <= mark;
            proto_err <= perr;
            if (emit) begin
                rec_addr  <= {rx_data_p0[3:0], lo};
                rec_slot  <= slot;
                err_count <= sat_inc16(err_count);
            end
            if (mark)
                rec_freq_idx <= sat_inc9(rec_freq_idx);
        end
    end

endmodule

// File: tb/tb_ram_report_rx.sv
// Scoreboard bench for ram_report_rx: directed byte sequences, expected pulses
// queued at send time and matched by an independent output monitor.
module tb_ram_report_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        UART_RXD;
    logic        rec_valid;
    logic [9:0]  rec_addr;
    logic        rec_slot;
    logic [8:0]  rec_freq_idx;
    logic        freq_mark;
    logic [15:0] err_count;
    logic        proto_err;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rec;
        logic        fm;
        logic        pe;
        logic        fe;
        logic [9:0]  addr;
        logic        slot;
        logic [15:0] cnt;
        logic [8:0]  fidx;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    ram_report_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .UART_RXD    (UART_RXD),
        .rec_valid   (rec_valid),
        .rec_addr    (rec_addr),
        .rec_slot    (rec_slot),
        .rec_freq_idx(rec_freq_idx),
        .freq_mark   (freq_mark),
        .err_count   (err_count),
        .proto_err   (proto_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic rec, input logic fm, input logic pe, input logic fe,
                             input logic [9:0] addr, input logic slot,
                             input logic [15:0] cnt, input logic [8:0] fidx);
        ev_t e;
        e = '{rec: rec, fm: fm, pe: pe, fe: fe, addr: addr, slot: slot, cnt: cnt, fidx: fidx};
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) UART_RXD = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) UART_RXD = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) UART_RXD = stop;
        repeat (CPB - 1) @(negedge clk);
        if (!stop) begin
            @(negedge clk) UART_RXD = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk) UART_RXD = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (rec_valid || freq_mark || proto_err || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rec=%0b fm=%0b pe=%0b fe=%0b, expected none",
                         rec_valid, freq_mark, proto_err, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_valid", 32'(rec_valid), 32'(mon_e.rec));
                chk("freq_mark", 32'(freq_mark), 32'(mon_e.fm));
                chk("proto_err", 32'(proto_err), 32'(mon_e.pe));
                chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
                chk("err_count", 32'(err_count), 32'(mon_e.cnt));
                chk("rec_freq_idx", 32'(rec_freq_idx), 32'(mon_e.fidx));
                if (mon_e.rec) begin
                    chk("rec_addr", 32'(rec_addr), 32'(mon_e.addr));
                    chk("rec_slot", 32'(rec_slot), 32'(mon_e.slot));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rec_valid"}, 32'(rec_valid), 0);
        chk({tag, "_rec_addr"}, 32'(rec_addr), 0);
        chk({tag, "_rec_slot"}, 32'(rec_slot), 0);
        chk({tag, "_rec_freq_idx"}, 32'(rec_freq_idx), 0);
        chk({tag, "_freq_mark"}, 32'(freq_mark), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
        chk({tag, "_proto_err"}, 32'(proto_err), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        UART_RXD = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");

        // Single pair: 0x2A5 in slot 0
        expect_ev(1, 0, 0, 0, 10'h2A5, 0, 16'd1, 9'd0);
        send_byte(8'h40, 1); send_byte(8'h25, 1); send_byte(8'h0A, 1);

        // Two pairs, then a data byte in IDLE proves the decoder returned there
        expect_ev(1, 0, 0, 0, 10'h3FF, 0, 16'd2, 9'd0);
        expect_ev(1, 0, 0, 0, 10'h000, 1, 16'd3, 9'd0);
        expect_ev(0, 0, 1, 0, 10'h000, 0, 16'd3, 9'd0);
        send_byte(8'h40, 1); send_byte(8'h3F, 1); send_byte(8'h0F, 1);
        send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h05, 1);

        // Frequency markers, then a marker breaking a pair
        expect_ev(0, 1, 0, 0, 10'h0, 0, 16'd3, 9'd1);
        expect_ev(0, 1, 0, 0, 10'h0, 0, 16'd3, 9'd2);
        expect_ev(0, 1, 0, 0, 10'h0, 0, 16'd3, 9'd3);
        expect_ev(0, 1, 1, 0, 10'h0, 0, 16'd3, 9'd4);
        send_byte(8'h7F, 1); send_byte(8'h7F, 1); send_byte(8'h7F, 1);
        send_byte(8'h40, 1); send_byte(8'h05, 1); send_byte(8'h7F, 1);

        // Framing error inside a pair leaves the decoder untouched
        expect_ev(0, 0, 0, 1, 10'h0, 0, 16'd3, 9'd4);
        expect_ev(1, 0, 0, 0, 10'h2A5, 0, 16'd4, 9'd4);
        expect_ev(0, 1, 0, 0, 10'h0, 0, 16'd4, 9'd5);
        send_byte(8'h40, 1); send_byte(8'h25, 1); send_byte(8'h55, 0);
        send_byte(8'h0A, 1); send_byte(8'h7F, 1);

        // Bad high byte discards the pair; frequency values are ignored; 0x40 restarts
        expect_ev(0, 0, 1, 0, 10'h0, 0, 16'd4, 9'd5);
        expect_ev(1, 0, 0, 0, 10'h0C2, 0, 16'd5, 9'd5);
        expect_ev(1, 0, 0, 0, 10'h007, 0, 16'd6, 9'd5);
        expect_ev(0, 1, 0, 0, 10'h0, 0, 16'd6, 9'd6);
        send_byte(8'h40, 1); send_byte(8'h01, 1); send_byte(8'h1F, 1);
        send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h45, 1);
        send_byte(8'h40, 1); send_byte(8'h07, 1); send_byte(8'h00, 1);
        send_byte(8'h7F, 1);

        // Short low glitch is a false start; 0x9C is illegal
        @(negedge clk) UART_RXD = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(3);
        expect_ev(0, 0, 1, 0, 10'h0, 0, 16'd6, 9'd6);
        send_byte(8'h9C, 1);
        idle_bits(2);
        chk("queue_drained_pre_reset", 32'(exp_q.size()), 0);

        // Reset in the middle of 0x40's data bits, released during its stop bit
        fork
            send_byte(8'h40, 1);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                reset = 1'b1;
                repeat (4 * CPB) @(negedge clk);
                reset = 1'b0;
            end
        join
        idle_bits(2);
        check_all_zero("post_reset");

        expect_ev(1, 0, 0, 0, 10'h001, 0, 16'd1, 9'd0);
        send_byte(8'h40, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
        idle_bits(3);
        chk("queue_drained_end", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
